// File: rtl/raisin64_bus_pkg.sv
// Shared types and helpers for the Raisin64 external memory bus arbiter.
// Lane masks are little-endian and computed for an 8-lane bus; narrower buses truncate.
package raisin64_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [1:0] SZ_8  = 2'd0;
  localparam logic [1:0] SZ_16 = 2'd1;
  localparam logic [1:0] SZ_32 = 2'd2;
  localparam logic [1:0] SZ_64 = 2'd3;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_8:    base = 8'h01;
      SZ_16:   base = 8'h03;
      SZ_32:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_8:    return 3'b000;
      SZ_16:   return 3'b001;
      SZ_32:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  always_comb begin
    int k;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = (int'(ptr) + i) % NUM_PORTS;
      if (grant == '0 && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and single-cycle-per-request bus master for the Raisin64 memory bus.
// Illegal requests are answered with done+err without touching the bus.
module mem_bus_arbiter
  import raisin64_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [2*NUM_PORTS-1:0]      port_size,
  input  logic [ADDR_W*NUM_PORTS-1:0] port_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] port_wdata,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_dout,
  output logic [DATA_W/8-1:0]         mem_byte_en,
  output logic                        mem_addr_valid,
  output logic                        mem_dout_write,
  input  logic [DATA_W-1:0]           mem_din,
  input  logic                        mem_din_ready
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg, gnt_reg, grant_idx, ptr_inc;
  logic [CNT_W-1:0]     cnt_reg;
  logic [1:0]           lat_size_reg;
  logic [OFF_W-1:0]     lat_off_reg;
  logic [NUM_PORTS-1:0] grant, done_vec;

  logic                 grant_any, req_bad, timed_out, sel_we;
  logic [1:0]           sel_size;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata, wmask, rmask, wdata_lane, rdata_ext;
  logic [OFF_W-1:0]     sel_off;
  logic [BE_W-1:0]      wsize_be, rsize_be;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (
    .req       (port_req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;
  assign ptr_inc   = IDX_W'((int'(grant_idx) + 1) % NUM_PORTS);
  assign sel_we    = port_we[grant_idx];
  assign sel_size  = port_size[int'(grant_idx)*2 +: 2];
  assign sel_addr  = port_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = port_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_off   = sel_addr[OFF_W-1:0];
  assign req_bad   = (sel_size > MAX_SIZE) || (|(sel_addr[2:0] & align_mask(sel_size)));
  assign timed_out = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT));
  assign done_vec  = NUM_PORTS'(1) << gnt_reg;

  // Size masks at lane 0, expanded to bit masks for write truncation and read extraction.
  assign wsize_be = BE_W'(lane_mask(sel_size, 3'd0));
  assign rsize_be = BE_W'(lane_mask(lat_size_reg, 3'd0));
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
    assign wmask[gi*8 +: 8] = {8{wsize_be[gi]}};
    assign rmask[gi*8 +: 8] = {8{rsize_be[gi]}};
  end

  assign wdata_lane = (sel_wdata & wmask) << {sel_off, 3'b000};
  assign rdata_ext  = (mem_din >> {lat_off_reg, 3'b000}) & rmask;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = req_bad ? RESP : BUS;
      BUS:     if (mem_din_ready || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      gnt_reg        <= '0;
      cnt_reg        <= '0;
      lat_size_reg   <= '0;
      lat_off_reg    <= '0;
      port_rdata     <= '0;
      port_done      <= '0;
      port_err       <= '0;
      mem_addr       <= '0;
      mem_dout       <= '0;
      mem_byte_en    <= '0;
      mem_addr_valid <= 1'b0;
      mem_dout_write <= 1'b0;
    end else begin
      state_reg <= state_next;
      port_done <= '0;
      port_err  <= '0;
      case (state_reg)
        IDLE: if (grant_any) begin
          gnt_reg      <= grant_idx;
          ptr_reg      <= ptr_inc;
          lat_size_reg <= sel_size;
          lat_off_reg  <= sel_off;
          cnt_reg      <= '0;
          if (req_bad) begin
            port_done <= grant;
            port_err  <= grant;
          end else begin
            mem_addr_valid <= 1'b1;
            mem_dout_write <= sel_we;
            mem_addr       <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_dout       <= wdata_lane;
            mem_byte_en    <= BE_W'(lane_mask(sel_size, 3'(sel_off)));
          end
        end
        BUS: begin
          // Ready takes precedence over an expiring timeout on the same edge.
          if (mem_din_ready || timed_out) begin
            mem_addr_valid <= 1'b0;
            mem_dout_write <= 1'b0;
            mem_byte_en    <= '0;
            port_done      <= done_vec;
            if (!mem_din_ready)
              port_err <= done_vec;
            else if (!mem_dout_write)
              port_rdata <= rdata_ext;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised self-checking bench for mem_bus_arbiter: a 64-bit instance (TIMEOUT=4)
// checked against an arithmetic lane model, plus a 32-bit instance for narrow-bus lanes.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic [1:0]   a_req = '0, a_we = '0, a_done, a_err;
  logic [3:0]   a_size = '0;
  logic [127:0] a_addr = '0, a_wdata = '0;
  logic [63:0]  a_rdata, a_maddr, a_mdout, a_din = '0;
  logic [7:0]   a_be;
  logic         a_valid, a_write, a_ready = 1'b0;

  // 32-bit instance
  logic [1:0]   b_req = '0, b_we = '0, b_done, b_err;
  logic [3:0]   b_size = '0;
  logic [127:0] b_addr = '0;
  logic [63:0]  b_wdata = '0, b_maddr;
  logic [31:0]  b_rdata, b_mdout, b_din = '0;
  logic [3:0]   b_be;
  logic         b_valid, b_write, b_ready = 1'b0;

  mem_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .port_req(a_req), .port_we(a_we), .port_size(a_size),
    .port_addr(a_addr), .port_wdata(a_wdata), .port_rdata(a_rdata), .port_done(a_done),
    .port_err(a_err), .mem_addr(a_maddr), .mem_dout(a_mdout), .mem_byte_en(a_be),
    .mem_addr_valid(a_valid), .mem_dout_write(a_write), .mem_din(a_din), .mem_din_ready(a_ready)
  );

  mem_bus_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .port_req(b_req), .port_we(b_we), .port_size(b_size),
    .port_addr(b_addr), .port_wdata(b_wdata), .port_rdata(b_rdata), .port_done(b_done),
    .port_err(b_err), .mem_addr(b_maddr), .mem_dout(b_mdout), .mem_byte_en(b_be),
    .mem_addr_valid(b_valid), .mem_dout_write(b_write), .mem_din(b_din), .mem_din_ready(b_ready)
  );

  int n_checks = 0, n_fail = 0;
  int exp_ptr = 0;
  logic [63:0] exp_rdata = '0;

  // Observations from the last run64 transaction
  int o_done_cyc, o_valid_cyc, o_bus_cycles;
  logic [1:0] o_done, o_err, o_done_after;
  logic [63:0] o_addr, o_dout, o_rdata;
  logic [7:0] o_be;
  logic o_write, o_unstable;

  // Reference model: plain arithmetic on byte counts for a 64-bit bus.
  function automatic logic [7:0] m_be(input int size, input logic [63:0] addr);
    int nbytes = 1 << size;
    return 8'(((1 << nbytes) - 1) << int'(addr % 8));
  endfunction

  function automatic logic [63:0] m_place(input logic [63:0] data, input int size, input logic [63:0] addr);
    logic [127:0] t = {64'd0, data};
    t = t % (128'd1 << (8 * (1 << size)));
    t = t << (8 * int'(addr % 8));
    return t[63:0];
  endfunction

  function automatic logic [63:0] m_extract(input logic [63:0] din, input int size, input logic [63:0] addr);
    logic [127:0] t = {64'd0, din};
    t = t >> (8 * int'(addr % 8));
    return 64'(t % (128'd1 << (8 * (1 << size))));
  endfunction

  // Drives one request on the 64-bit instance and plays memory; ready comes on the
  // (ready_at+1)-th bus cycle, never if ready_at < 0.
  task automatic run64(input int p, input logic we, input logic [1:0] size,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] din, input int ready_at);
    @(negedge clk);
    a_req[p] = 1'b1;
    a_we[p] = we;
    a_size[p*2 +: 2] = size;
    a_addr[p*64 +: 64] = addr;
    a_wdata[p*64 +: 64] = wdata;
    a_din = din;
    a_ready = 1'b0;
    o_done_cyc = -1; o_valid_cyc = -1; o_bus_cycles = 0;
    o_done = '0; o_err = '0; o_unstable = 1'b0; o_rdata = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (a_valid) begin
        if (o_bus_cycles == 0) begin
          o_valid_cyc = c;
          o_addr = a_maddr; o_dout = a_mdout; o_be = a_be; o_write = a_write;
        end else if ({a_maddr, a_mdout, a_be, a_write} !== {o_addr, o_dout, o_be, o_write}) begin
          o_unstable = 1'b1;
        end
        o_bus_cycles++;
        a_ready = (o_bus_cycles - 1 == ready_at);
      end else begin
        a_ready = 1'b0;
      end
      if (a_done != '0) begin
        o_done_cyc = c; o_done = a_done; o_err = a_err; o_rdata = a_rdata;
        a_req[p] = 1'b0;
        break;
      end
    end
    a_req[p] = 1'b0;
    a_ready = 1'b0;
    @(negedge clk);
    o_done_after = a_done;
    $display("txn64 port=%0d we=%0d size=%0d addr=%h ready_at=%0d done=%b err=%b done_cyc=%0d valid_cyc=%0d rdata=%h",
             p, we, size, addr, ready_at, o_done, o_err, o_done_cyc, o_valid_cyc, o_rdata);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_write, a_be, a_maddr, a_mdout, a_done, a_err, a_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset64 outputs: valid=%b write=%b be=%h addr=%h dout=%h done=%b err=%b rdata=%h, required all zero",
               a_valid, a_write, a_be, a_maddr, a_mdout, a_done, a_err, a_rdata);
    end
    n_checks++;
    if ({b_valid, b_write, b_be, b_maddr, b_mdout, b_done, b_err, b_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset32 outputs: valid=%b write=%b be=%h addr=%h dout=%h done=%b err=%b rdata=%h, required all zero",
               b_valid, b_write, b_be, b_maddr, b_mdout, b_done, b_err, b_rdata);
    end
    rst_n = 1'b1;
    exp_ptr = 0;
    exp_rdata = '0;
  endtask

  task automatic test_single_read;
    run64(0, 1'b0, 2'd0, 64'h13, 64'h0, 64'h8877665544332211, 0);
    exp_ptr = 1;
    exp_rdata = 64'h44;
    n_checks++;
    if (o_be !== 8'h08) begin n_fail++; $display("FAIL single_read byte_en: got %h, required 08", o_be); end
    n_checks++;
    if (o_addr !== 64'h10) begin n_fail++; $display("FAIL single_read mem_addr: got %h, required 10", o_addr); end
    n_checks++;
    if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL single_read rdata: got %h, required %h", o_rdata, exp_rdata); end
    n_checks++;
    if (o_done_cyc != 2 || o_done !== 2'b01 || o_err !== 2'b00) begin
      n_fail++;
      $display("FAIL single_read done: cyc=%0d done=%b err=%b, required cyc=2 done=01 err=00", o_done_cyc, o_done, o_err);
    end
    n_checks++;
    if (o_done_after !== 2'b00) begin n_fail++; $display("FAIL single_read done_width: got %b a cycle later, required 00", o_done_after); end
  endtask

  task automatic test_misalign;
    run64(1, 1'b1, 2'd2, 64'h6, 64'hDEADBEEF, 64'h0, 0);
    exp_ptr = 0;
    n_checks++;
    if (o_bus_cycles != 0) begin n_fail++; $display("FAIL misalign bus_cycles: got %0d, required 0", o_bus_cycles); end
    n_checks++;
    if (o_done_cyc != 1 || o_done !== 2'b10 || o_err !== 2'b10) begin
      n_fail++;
      $display("FAIL misalign done: cyc=%0d done=%b err=%b, required cyc=1 done=10 err=10", o_done_cyc, o_done, o_err);
    end
  endtask

  task automatic test_timeout;
    logic [63:0] din;
    run64(0, 1'b0, 2'd3, 64'h40, 64'h0, 64'h0123456789ABCDEF, -1);
    n_checks++;
    if (o_err !== 2'b01 || o_done_cyc - o_valid_cyc != 5) begin
      n_fail++;
      $display("FAIL timeout_expire: err=%b latency=%0d, required err=01 latency=5", o_err, o_done_cyc - o_valid_cyc);
    end
    n_checks++;
    if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL timeout_hold rdata: got %h, required %h", o_rdata, exp_rdata); end
    din = {$urandom, $urandom};
    run64(0, 1'b0, 2'd3, 64'h48, 64'h0, din, 4);
    exp_rdata = din;
    exp_ptr = 1;
    n_checks++;
    if (o_err !== 2'b00 || o_done !== 2'b01 || o_done_cyc - o_valid_cyc != 5) begin
      n_fail++;
      $display("FAIL timeout_ready_wins: done=%b err=%b latency=%0d, required done=01 err=00 latency=5",
               o_done, o_err, o_done_cyc - o_valid_cyc);
    end
    n_checks++;
    if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL timeout_ready_wins rdata: got %h, required %h", o_rdata, exp_rdata); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 24; t++) begin
      int p, size, ready_at, lat;
      logic we, legal, exp_err;
      logic [63:0] addr, wdata, din;
      p = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      size = int'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % (64'd1 << size));
      wdata = {$urandom, $urandom};
      din = {$urandom, $urandom};
      ready_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      legal = (addr % (64'd1 << size)) == 0;
      exp_err = !legal || ready_at < 0;
      run64(p, we, 2'(size), addr, wdata, din, ready_at);
      if (legal && !we && ready_at >= 0) exp_rdata = m_extract(din, size, addr);
      n_checks++;
      if (o_done !== 2'(1 << p) || o_err !== (exp_err ? 2'(1 << p) : 2'b00)) begin
        n_fail++;
        $display("FAIL random[%0d] done/err: done=%b err=%b, required done=%b err=%b",
                 t, o_done, o_err, 2'(1 << p), exp_err ? 2'(1 << p) : 2'b00);
      end
      n_checks++;
      if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL random[%0d] rdata: got %h, required %h", t, o_rdata, exp_rdata); end
      n_checks++;
      if (o_done_after !== 2'b00) begin n_fail++; $display("FAIL random[%0d] done_width: got %b, required 00", t, o_done_after); end
      if (legal) begin
        lat = (ready_at < 0) ? 5 : ready_at + 1;
        n_checks++;
        if (o_valid_cyc != 1 || o_done_cyc - o_valid_cyc != lat) begin
          n_fail++;
          $display("FAIL random[%0d] timing: valid_cyc=%0d latency=%0d, required valid_cyc=1 latency=%0d",
                   t, o_valid_cyc, o_done_cyc - o_valid_cyc, lat);
        end
        n_checks++;
        if (o_be !== m_be(size, addr) || o_addr !== addr - (addr % 8) || o_write !== we || o_unstable !== 1'b0) begin
          n_fail++;
          $display("FAIL random[%0d] bus: be=%h addr=%h write=%b unstable=%b, required be=%h addr=%h write=%b unstable=0",
                   t, o_be, o_addr, o_write, o_unstable, m_be(size, addr), addr - (addr % 8), we);
        end
        if (we) begin
          n_checks++;
          if (o_dout !== m_place(wdata, size, addr)) begin
            n_fail++;
            $display("FAIL random[%0d] dout: got %h, required %h", t, o_dout, m_place(wdata, size, addr));
          end
        end
      end else begin
        n_checks++;
        if (o_bus_cycles != 0 || o_done_cyc != 1) begin
          n_fail++;
          $display("FAIL random[%0d] misalign: bus_cycles=%0d done_cyc=%0d, required 0 and 1", t, o_bus_cycles, o_done_cyc);
        end
      end
    end
    exp_ptr = 0;  // recomputed below from the last port; kept simple by a final known request
    run64(1, 1'b1, 2'd0, 64'h0, 64'h0, 64'h0, 0);
    exp_ptr = 0;
  endtask

  task automatic test_contention;
    int grants[$];
    int gaps[$];
    int gap = 0;
    logic prev_valid = 1'b0;
    logic [63:0] din = {$urandom, $urandom};
    @(negedge clk);
    a_we = 2'b00;
    a_size = {2'd3, 2'd3};
    a_addr = {64'h208, 64'h100};
    a_din = din;
    a_ready = 1'b0;
    a_req = 2'b11;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (a_valid) begin
        if (!prev_valid && grants.size() > 0) gaps.push_back(gap);
        gap = 0;
        a_ready = 1'b1;
      end else begin
        gap++;
        a_ready = 1'b0;
      end
      prev_valid = a_valid;
      if (a_done != '0) begin
        grants.push_back((a_done == 2'b10) ? 1 : 0);
        $display("contention grant %0d -> port done=%b", grants.size(), a_done);
        if (grants.size() == 4) begin
          a_req = 2'b00;
          break;
        end
      end
    end
    a_req = 2'b00;
    a_ready = 1'b0;
    n_checks++;
    if (grants.size() != 4) begin n_fail++; $display("FAIL contention grant_count: got %0d, required 4", grants.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) begin
        n_checks++;
        if (grants[i] != (exp_ptr + i) % 2) begin
          n_fail++;
          $display("FAIL contention order[%0d]: got port %0d, required port %0d", i, grants[i], (exp_ptr + i) % 2);
        end
      end
    end
    n_checks++;
    if (gaps.size() != 3) begin n_fail++; $display("FAIL contention gap_count: got %0d, required 3", gaps.size()); end
    foreach (gaps[i]) begin
      n_checks++;
      if (gaps[i] != 2) begin n_fail++; $display("FAIL contention gap[%0d]: got %0d low cycles, required 2", i, gaps[i]); end
    end
    exp_rdata = din;
    n_checks++;
    if (a_rdata !== exp_rdata) begin n_fail++; $display("FAIL contention rdata: got %h, required %h", a_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid;
    int seen_valid = 0, stray_done = 0, done_cyc = -1;
    logic [1:0] first_done = '0;
    logic [63:0] din = {$urandom, $urandom};
    @(negedge clk);
    a_we = 2'b00;
    a_size = {2'd3, 2'd3};
    a_addr = {64'h318, 64'h300};
    a_ready = 1'b0;
    a_req = 2'b01;
    for (int c = 0; c < 10 && seen_valid == 0; c++) begin
      @(negedge clk);
      if (a_valid) seen_valid = 1;
    end
    n_checks++;
    if (seen_valid != 1) begin n_fail++; $display("FAIL reset_mid bus_start: valid seen=%0d, required 1", seen_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_write, a_be, a_maddr, a_mdout, a_done, a_err, a_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: valid=%b write=%b be=%h addr=%h dout=%h done=%b err=%b rdata=%h, required all zero",
               a_valid, a_write, a_be, a_maddr, a_mdout, a_done, a_err, a_rdata);
    end
    rst_n = 1'b1;
    a_req = 2'b00;
    repeat (3) begin
      @(negedge clk);
      if (a_done != '0) stray_done++;
    end
    n_checks++;
    if (stray_done != 0) begin n_fail++; $display("FAIL reset_mid stray_done: got %0d pulses, required 0", stray_done); end
    a_din = din;
    a_req = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      a_ready = a_valid;
      if (a_done != '0) begin
        first_done = a_done;
        done_cyc = c;
        a_req = 2'b00;
        break;
      end
    end
    a_req = 2'b00;
    a_ready = 1'b0;
    $display("reset_mid first grant done=%b at cycle %0d", first_done, done_cyc);
    exp_ptr = 1;
    exp_rdata = din;
    n_checks++;
    if (first_done !== 2'b01) begin n_fail++; $display("FAIL reset_mid pointer: first done=%b, required 01", first_done); end
    n_checks++;
    if (a_rdata !== exp_rdata) begin n_fail++; $display("FAIL reset_mid rdata: got %h, required %h", a_rdata, exp_rdata); end
  endtask

  task automatic test_lanes32;
    int seen = 0;
    logic [1:0] d = '0, e = '0;
    @(negedge clk);
    b_we = 2'b01;
    b_size[1:0] = 2'd1;
    b_addr[63:0] = 64'h2;
    b_wdata = 64'h1234BEEF;
    b_ready = 1'b0;
    b_req = 2'b01;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (b_valid) seen = 1;
    end
    $display("txn32 write size=1 addr=2 dout=%h be=%h write=%b addr=%h", b_mdout, b_be, b_write, b_maddr);
    n_checks++;
    if (seen != 1 || b_mdout !== 32'hBEEF0000 || b_be !== 4'hC || b_write !== 1'b1 || b_maddr !== 64'h0) begin
      n_fail++;
      $display("FAIL lanes32 write: valid=%0d dout=%h be=%h write=%b addr=%h, required 1 BEEF0000 c 1 0",
               seen, b_mdout, b_be, b_write, b_maddr);
    end
    b_ready = 1'b1;
    @(negedge clk);
    d = b_done; e = b_err;
    b_ready = 1'b0;
    b_req = 2'b00;
    n_checks++;
    if (d !== 2'b01 || e !== 2'b00) begin n_fail++; $display("FAIL lanes32 write_done: done=%b err=%b, required 01 00", d, e); end
    repeat (2) @(negedge clk);
    seen = 0; d = '0; e = '0;
    b_we = 2'b00;
    b_size[1:0] = 2'd3;
    b_addr[63:0] = 64'h8;
    b_req = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_valid) seen = 1;
      if (b_done != '0) begin
        d = b_done; e = b_err;
        break;
      end
    end
    b_req = 2'b00;
    $display("txn32 read size=3 addr=8 done=%b err=%b valid_seen=%0d", d, e, seen);
    n_checks++;
    if (d !== 2'b01 || e !== 2'b01 || seen != 0) begin
      n_fail++;
      $display("FAIL lanes32 oversize: done=%b err=%b valid_seen=%0d, required 01 01 0", d, e, seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_misalign();
    test_timeout();
    test_random();
    test_contention();
    test_reset_mid();
    test_lanes32();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
